// File: rtl/icache_ctrl_nway_pkg.sv
// Purpose: shared types, default geometry and helpers for the N-way
//          instruction cache controller.
// Contents: icache_state_t FSM encoding, default TAGBITS/WAYS/WORDS,
//           WAYBITS/WORDBITS widths for the default geometry, and a
//           onehot() helper sized for the largest supported associativity.
package icache_pkg;

    localparam int unsigned DEF_TAGBITS = 14;
    localparam int unsigned DEF_WAYS    = 4;
    localparam int unsigned DEF_WORDS   = 4;
    localparam int unsigned MAX_WAYS    = 8;

    localparam int unsigned WAYBITS  = $clog2(DEF_WAYS);
    localparam int unsigned WORDBITS = $clog2(DEF_WORDS);

    typedef enum logic [1:0] {
        READY  = 2'd0,
        FILL   = 2'd1,
        RESUME = 2'd2
    } icache_state_t;

    // One-hot decode of a way index; callers truncate to their WAYS.
    function automatic logic [MAX_WAYS-1:0] onehot(input logic [2:0] idx);
        onehot      = '0;
        onehot[idx] = 1'b1;
    endfunction

endpackage

// File: rtl/icache_ctrl_nway_if.sv
// Purpose: fetch/array/bus signal bundle of the N-way icache controller.
// master: controller side (drives Hit, HitWay, WayWE, IStall, HRequestF,
//         FillWordOffset, UseValid, UseWay; HitCount/MissCount when
//         ICACHE_STATS_EN is defined).
// slave:  environment side (drives WayValid, WayTags, Tag, WordOffset,
//         ReplWay, BusReady).
interface icache_ctrl_nway_if #(
    parameter int unsigned TAGBITS = 14,
    parameter int unsigned WAYS    = 4,
    parameter int unsigned WORDS   = 4
);
    localparam int unsigned WAY_W  = $clog2(WAYS);
    localparam int unsigned WORD_W = $clog2(WORDS);

    logic [WAYS-1:0]         WayValid;
    logic [WAYS*TAGBITS-1:0] WayTags;
    logic [TAGBITS-1:0]      Tag;
    logic [WORD_W-1:0]       WordOffset;
    logic [WAY_W-1:0]        ReplWay;
    logic                    BusReady;
    logic                    Hit;
    logic [WAY_W-1:0]        HitWay;
    logic [WAYS-1:0]         WayWE;
    logic                    IStall;
    logic                    HRequestF;
    logic [WORD_W-1:0]       FillWordOffset;
    logic                    UseValid;
    logic [WAY_W-1:0]        UseWay;
`ifdef ICACHE_STATS_EN
    logic [31:0]             HitCount;
    logic [31:0]             MissCount;
`endif

    modport master (
        input  WayValid, WayTags, Tag, WordOffset, ReplWay, BusReady,
        output Hit, HitWay, WayWE, IStall, HRequestF, FillWordOffset,
               UseValid, UseWay
`ifdef ICACHE_STATS_EN
        , output HitCount, MissCount
`endif
    );

    modport slave (
        output WayValid, WayTags, Tag, WordOffset, ReplWay, BusReady,
        input  Hit, HitWay, WayWE, IStall, HRequestF, FillWordOffset,
               UseValid, UseWay
`ifdef ICACHE_STATS_EN
        , input HitCount, MissCount
`endif
    );

endinterface

// File: rtl/icache_ctrl_nway_way_hit.sv
// Purpose: parallel tag compare across all ways plus lowest-index priority
//          encoders for the hit way and the first invalid way.
// Ports: way_valid/way_tags (indexed set), tag (fetch tag) in;
//        hit, hit_way, first_invalid, all_valid out (combinational).
module icache_way_hit #(
    parameter int unsigned TAGBITS = 14,
    parameter int unsigned WAYS    = 4
) (
    input  logic [WAYS-1:0]          way_valid,
    input  logic [WAYS*TAGBITS-1:0]  way_tags,
    input  logic [TAGBITS-1:0]       tag,
    output logic                     hit,
    output logic [$clog2(WAYS)-1:0]  hit_way,
    output logic [$clog2(WAYS)-1:0]  first_invalid,
    output logic                     all_valid
);
    localparam int unsigned WAY_W = $clog2(WAYS);

    // Ascending scan; the first match/invalid found is the lowest index.
    always_comb begin
        hit           = 1'b0;
        hit_way       = '0;
        first_invalid = '0;
        all_valid     = 1'b1;
        for (int unsigned i = 0; i < WAYS; i++) begin
            if (way_valid[i] && (way_tags[i*TAGBITS +: TAGBITS] == tag) && !hit) begin
                hit     = 1'b1;
                hit_way = WAY_W'(i);
            end
            if (!way_valid[i] && all_valid) begin
                all_valid     = 1'b0;
                first_invalid = WAY_W'(i);
            end
        end
    end

endmodule

// File: rtl/icache_ctrl_nway.sv
// Purpose: N-way set-associative instruction cache controller. Detects
//          hits, picks a victim on a miss and runs a critical-word-first
//          wrapping line fill over the bus, then strobes the replacement
//          array with the used way.
// Ports: clk, reset (async, active-high); bus (icache_ctrl_nway_if.master)
//        carrying the fetch, tag-array, replacement and bus signals.
// Config: define ICACHE_STATS_EN to add saturating HitCount/MissCount.
module icache_ctrl_nway
    import icache_pkg::*;
#(
    parameter int unsigned TAGBITS = DEF_TAGBITS,
    parameter int unsigned WAYS    = DEF_WAYS,
    parameter int unsigned WORDS   = DEF_WORDS
) (
    input  logic              clk,
    input  logic              reset,
    icache_ctrl_nway_if.master bus
);
    localparam int unsigned WAY_W  = $clog2(WAYS);
    localparam int unsigned WORD_W = $clog2(WORDS);

    icache_state_t     state_q, state_d;
    logic [WORD_W-1:0] cnt_q, cnt_d;
    logic [WORD_W-1:0] start_q, start_d;
    logic [WAY_W-1:0]  victim_q, victim_d;

    logic              hit_c;
    logic [WAY_W-1:0]  hit_way_c;
    logic [WAY_W-1:0]  first_inv_c;
    logic              all_valid_c;
    logic [WAY_W-1:0]  victim_c;

    logic [WAYS-1:0]   way_we_c;
    logic              istall_c;
    logic              hreq_c;
    logic [WORD_W-1:0] fill_off_c;
    logic              use_valid_c;
    logic [WAY_W-1:0]  use_way_c;

    icache_way_hit #(
        .TAGBITS (TAGBITS),
        .WAYS    (WAYS)
    ) u_way_hit (
        .way_valid     (bus.WayValid),
        .way_tags      (bus.WayTags),
        .tag           (bus.Tag),
        .hit           (hit_c),
        .hit_way       (hit_way_c),
        .first_invalid (first_inv_c),
        .all_valid     (all_valid_c)
    );

    // Replacement array only decides when the set has no free way.
    assign victim_c = all_valid_c ? bus.ReplWay : first_inv_c;

    // Next-state and output decode.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        start_d     = start_q;
        victim_d    = victim_q;
        way_we_c    = '0;
        istall_c    = 1'b0;
        hreq_c      = 1'b0;
        fill_off_c  = bus.WordOffset;
        use_valid_c = 1'b0;
        use_way_c   = '0;
        unique case (state_q)
            READY: begin
                fill_off_c = bus.WordOffset + cnt_q;
                if (hit_c) begin
                    use_valid_c = 1'b1;
                    use_way_c   = hit_way_c;
                    cnt_d       = '0;
                end else begin
                    istall_c = 1'b1;
                    hreq_c   = 1'b1;
                    state_d  = FILL;
                    start_d  = bus.WordOffset;
                    victim_d = victim_c;
                    // First beat may already arrive with the request.
                    if (bus.BusReady) begin
                        way_we_c = WAYS'(onehot(3'(victim_c)));
                        cnt_d    = cnt_q + WORD_W'(1);
                    end
                end
            end
            FILL: begin
                istall_c   = 1'b1;
                hreq_c     = 1'b1;
                // WORDS is a power of two, so the sum wraps within the line.
                fill_off_c = start_q + cnt_q;
                if (bus.BusReady) begin
                    way_we_c = WAYS'(onehot(3'(victim_q)));
                    if (cnt_q == WORD_W'(WORDS - 1)) begin
                        state_d = RESUME;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + WORD_W'(1);
                    end
                end
            end
            RESUME: begin
                use_valid_c = 1'b1;
                use_way_c   = victim_q;
                state_d     = READY;
            end
            default: begin
                state_d = READY;
                cnt_d   = '0;
            end
        endcase
    end

    // State, beat counter and fill latches.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= READY;
            cnt_q    <= '0;
            start_q  <= '0;
            victim_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            start_q  <= start_d;
            victim_q <= victim_d;
        end
    end

    assign bus.Hit            = hit_c;
    assign bus.HitWay         = hit_way_c;
    assign bus.WayWE          = way_we_c;
    assign bus.IStall         = istall_c;
    assign bus.HRequestF      = hreq_c;
    assign bus.FillWordOffset = fill_off_c;
    assign bus.UseValid       = use_valid_c;
    assign bus.UseWay         = use_way_c;

`ifdef ICACHE_STATS_EN
    logic [31:0] hit_count_q, hit_count_d;
    logic [31:0] miss_count_q, miss_count_d;

    // Saturating hit/miss event counters.
    always_comb begin
        hit_count_d  = hit_count_q;
        miss_count_d = miss_count_q;
        if (state_q == READY && hit_c && hit_count_q != 32'hFFFF_FFFF)
            hit_count_d = hit_count_q + 32'd1;
        if (state_q == READY && !hit_c && miss_count_q != 32'hFFFF_FFFF)
            miss_count_d = miss_count_q + 32'd1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hit_count_q  <= '0;
            miss_count_q <= '0;
        end else begin
            hit_count_q  <= hit_count_d;
            miss_count_q <= miss_count_d;
        end
    end

    assign bus.HitCount  = hit_count_q;
    assign bus.MissCount = miss_count_q;
`endif

endmodule

// File: tb/tb_icache_ctrl_nway.sv
// Purpose: directed, table-driven bench for icache_ctrl_nway at the
//          default geometry (TAGBITS=14, WAYS=4, WORDS=4), plus hand
//          sequences for reset mid-fill and, with ICACHE_STATS_EN, the
//          hit/miss counters.
module tb_icache_ctrl_nway;

    typedef struct {
        logic [3:0]  valid;
        logic [55:0] tags;
        logic [13:0] tag;
        logic [1:0]  woff;
        logic [1:0]  repl;
        logic        br;
        logic        hit;
        logic [1:0]  hway;
        logic [3:0]  we;
        logic        stall;
        logic        req;
        logic [1:0]  fwo;
        logic        uv;
        logic [1:0]  uw;
    } vec_t;

    logic clk;
    logic reset;
    int   n_vec;
    int   n_err;
    vec_t vecs[$];

    icache_ctrl_nway_if #(.TAGBITS(14), .WAYS(4), .WORDS(4)) bif ();

    icache_ctrl_nway #(.TAGBITS(14), .WAYS(4), .WORDS(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [55:0] tg(input logic [13:0] t0, input logic [13:0] t1,
                                       input logic [13:0] t2, input logic [13:0] t3);
        tg = {t3, t2, t1, t0};
    endfunction

    function automatic vec_t mk(input logic [3:0] valid, input logic [55:0] tags,
                                input logic [13:0] tag, input logic [1:0] woff,
                                input logic [1:0] repl, input logic br,
                                input logic hit, input logic [1:0] hway,
                                input logic [3:0] we, input logic stall,
                                input logic req, input logic [1:0] fwo,
                                input logic uv, input logic [1:0] uw);
        vec_t v;
        v.valid = valid; v.tags = tags; v.tag = tag; v.woff = woff;
        v.repl = repl; v.br = br; v.hit = hit; v.hway = hway; v.we = we;
        v.stall = stall; v.req = req; v.fwo = fwo; v.uv = uv; v.uw = uw;
        return v;
    endfunction

    task automatic drive(input vec_t v);
        bif.WayValid   = v.valid;
        bif.WayTags    = v.tags;
        bif.Tag        = v.tag;
        bif.WordOffset = v.woff;
        bif.ReplWay    = v.repl;
        bif.BusReady   = v.br;
    endtask

    // Field order: Hit HitWay WayWE IStall HRequestF FillWordOffset UseValid UseWay
    task automatic chk(input string name, input int idx, input vec_t v);
        logic [13:0] act;
        logic [13:0] exp;
        act = {bif.Hit, bif.HitWay, bif.WayWE, bif.IStall, bif.HRequestF,
               bif.FillWordOffset, bif.UseValid, bif.UseWay};
        exp = {v.hit, v.hway, v.we, v.stall, v.req, v.fwo, v.uv, v.uw};
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s[%0d]: got hit=%b hway=%0d we=%b stall=%b req=%b fwo=%0d uv=%b uw=%0d, want hit=%b hway=%0d we=%b stall=%b req=%b fwo=%0d uv=%b uw=%0d",
                     name, idx, act[13], act[12:11], act[10:7], act[6], act[5], act[4:3], act[2], act[1:0],
                     exp[13], exp[12:11], exp[10:7], exp[6], exp[5], exp[4:3], exp[2], exp[1:0]);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

`ifdef ICACHE_STATS_EN
    task automatic chk_cnt(input string name, input logic [31:0] hc, input logic [31:0] mc);
        n_vec++;
        if (bif.HitCount !== hc || bif.MissCount !== mc) begin
            n_err++;
            $display("FAIL %s: got HitCount=%h MissCount=%h, want HitCount=%h MissCount=%h",
                     name, bif.HitCount, bif.MissCount, hc, mc);
        end
    endtask
`endif

    initial begin
        vec_t v;
        n_vec = 0;
        n_err = 0;

        // Hit on way2; lowest index wins on a double match, BusReady ignored.
        vecs.push_back(mk(4'b0100, tg(14'h0, 14'h0, 14'h1A3, 14'h0), 14'h1A3, 2'd1, 2'd0, 1'b0,
                          1'b1, 2'd2, 4'b0000, 1'b0, 1'b0, 2'd1, 1'b1, 2'd2));
        vecs.push_back(mk(4'b1111, tg(14'h11, 14'h55, 14'h22, 14'h55), 14'h55, 2'd0, 2'd3, 1'b1,
                          1'b1, 2'd1, 4'b0000, 1'b0, 1'b0, 2'd0, 1'b1, 2'd1));
        // Miss, first invalid is way2, BusReady every cycle, start offset 1.
        for (int i = 0; i < 4; i++)
            vecs.push_back(mk(4'b0011, tg(14'h10, 14'h11, 14'h1A3, 14'h1A3), 14'h1A3, 2'd1, 2'd0, 1'b1,
                              1'b0, 2'd0, 4'b0100, 1'b1, 1'b1, 2'(1 + i), 1'b0, 2'd0));
        vecs.push_back(mk(4'b0011, tg(14'h10, 14'h11, 14'h1A3, 14'h1A3), 14'h1A3, 2'd1, 2'd0, 1'b1,
                          1'b0, 2'd0, 4'b0000, 1'b0, 1'b0, 2'd1, 1'b1, 2'd2));
        vecs.push_back(mk(4'b0111, tg(14'h10, 14'h11, 14'h1A3, 14'h1A3), 14'h1A3, 2'd1, 2'd0, 1'b0,
                          1'b1, 2'd2, 4'b0000, 1'b0, 1'b0, 2'd1, 1'b1, 2'd2));
        // All valid, ReplWay=3, start offset 2, BusReady 1,0,1,1,0,1.
        vecs.push_back(mk(4'b1111, tg(14'h1, 14'h2, 14'h3, 14'h4), 14'h3FFF, 2'd2, 2'd3, 1'b1,
                          1'b0, 2'd0, 4'b1000, 1'b1, 1'b1, 2'd2, 1'b0, 2'd0));
        vecs.push_back(mk(4'b1111, tg(14'h1, 14'h2, 14'h3, 14'h4), 14'h3FFF, 2'd2, 2'd3, 1'b0,
                          1'b0, 2'd0, 4'b0000, 1'b1, 1'b1, 2'd3, 1'b0, 2'd0));
        vecs.push_back(mk(4'b1111, tg(14'h1, 14'h2, 14'h3, 14'h4), 14'h3FFF, 2'd2, 2'd3, 1'b1,
                          1'b0, 2'd0, 4'b1000, 1'b1, 1'b1, 2'd3, 1'b0, 2'd0));
        vecs.push_back(mk(4'b1111, tg(14'h1, 14'h2, 14'h3, 14'h4), 14'h3FFF, 2'd2, 2'd3, 1'b1,
                          1'b0, 2'd0, 4'b1000, 1'b1, 1'b1, 2'd0, 1'b0, 2'd0));
        vecs.push_back(mk(4'b1111, tg(14'h1, 14'h2, 14'h3, 14'h4), 14'h3FFF, 2'd2, 2'd3, 1'b0,
                          1'b0, 2'd0, 4'b0000, 1'b1, 1'b1, 2'd1, 1'b0, 2'd0));
        vecs.push_back(mk(4'b1111, tg(14'h1, 14'h2, 14'h3, 14'h4), 14'h3FFF, 2'd2, 2'd3, 1'b1,
                          1'b0, 2'd0, 4'b1000, 1'b1, 1'b1, 2'd1, 1'b0, 2'd0));
        vecs.push_back(mk(4'b1111, tg(14'h1, 14'h2, 14'h3, 14'h4), 14'h3FFF, 2'd2, 2'd3, 1'b1,
                          1'b0, 2'd0, 4'b0000, 1'b0, 1'b0, 2'd2, 1'b1, 2'd3));
        // Victim latched as way1; Tag/WordOffset/ReplWay move mid-fill.
        vecs.push_back(mk(4'b1111, tg(14'h1, 14'h2, 14'h3, 14'h4), 14'h3FFF, 2'd0, 2'd1, 1'b1,
                          1'b0, 2'd0, 4'b0010, 1'b1, 1'b1, 2'd0, 1'b0, 2'd0));
        vecs.push_back(mk(4'b1111, tg(14'h1, 14'h2, 14'h3, 14'h4), 14'h0002, 2'd3, 2'd2, 1'b1,
                          1'b1, 2'd1, 4'b0010, 1'b1, 1'b1, 2'd1, 1'b0, 2'd0));
        vecs.push_back(mk(4'b1111, tg(14'h1, 14'h2, 14'h3, 14'h4), 14'h0777, 2'd1, 2'd0, 1'b1,
                          1'b0, 2'd0, 4'b0010, 1'b1, 1'b1, 2'd2, 1'b0, 2'd0));
        vecs.push_back(mk(4'b1111, tg(14'h1, 14'h2, 14'h3, 14'h4), 14'h0777, 2'd1, 2'd0, 1'b1,
                          1'b0, 2'd0, 4'b0010, 1'b1, 1'b1, 2'd3, 1'b0, 2'd0));
        vecs.push_back(mk(4'b1111, tg(14'h1, 14'h2, 14'h3, 14'h4), 14'h3FFF, 2'd1, 2'd0, 1'b1,
                          1'b0, 2'd0, 4'b0000, 1'b0, 1'b0, 2'd1, 1'b1, 2'd1));

        // Reset: READY with an empty set looks like a fresh miss, no beat yet.
        reset = 1'b1;
        v = mk(4'b0000, tg(14'h0, 14'h0, 14'h0, 14'h0), 14'h0, 2'd3, 2'd0, 1'b0,
               1'b0, 2'd0, 4'b0000, 1'b1, 1'b1, 2'd3, 1'b0, 2'd0);
        drive(v);
        @(negedge clk);
        chk("reset", 0, v);
        cyc();
        reset = 1'b0;

        foreach (vecs[i]) begin
            drive(vecs[i]);
            @(negedge clk);
            chk("table", i, vecs[i]);
            cyc();
        end

        // Reset after the second beat of a fill into way1.
        v = mk(4'b0001, tg(14'h5, 14'h0, 14'h0, 14'h0), 14'h9, 2'd0, 2'd0, 1'b1,
               1'b0, 2'd0, 4'b0010, 1'b1, 1'b1, 2'd0, 1'b0, 2'd0);
        drive(v);
        cyc();
        cyc();
        #1;
        reset   = 1'b1;
        bif.Tag = 14'h5;
        #1;
        v = mk(4'b0001, tg(14'h5, 14'h0, 14'h0, 14'h0), 14'h5, 2'd0, 2'd0, 1'b1,
               1'b1, 2'd0, 4'b0000, 1'b0, 1'b0, 2'd0, 1'b1, 2'd0);
        chk("rst_mid", 0, v);
        reset = 1'b0;
        // Empty set with ReplWay=3: way0 wins, counter restarts at 0.
        v = mk(4'b0000, tg(14'h5, 14'h0, 14'h0, 14'h0), 14'h9, 2'd2, 2'd3, 1'b1,
               1'b0, 2'd0, 4'b0001, 1'b1, 1'b1, 2'd2, 1'b0, 2'd0);
        drive(v);
        #1;
        chk("rst_mid", 1, v);
        cyc();
        v.fwo = 2'd3;
        chk("rst_mid", 2, v);
        v.br = 1'b0;
        v.we = 4'b0000;
        drive(v);
        #1;
        chk("rst_mid", 3, v);

`ifdef ICACHE_STATS_EN
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        chk_cnt("stats_reset", 32'd0, 32'd0);
        v = mk(4'b0001, tg(14'h5, 14'h0, 14'h0, 14'h0), 14'h5, 2'd0, 2'd0, 1'b0,
               1'b0, 2'd0, 4'b0000, 1'b0, 1'b0, 2'd0, 1'b0, 2'd0);
        drive(v);
        for (int i = 0; i < 3; i++) cyc();
        bif.Tag      = 14'h9;
        bif.BusReady = 1'b1;
        for (int i = 0; i < 4; i++) cyc();
        bif.Tag = 14'h5;
        cyc();
        for (int i = 0; i < 2; i++) cyc();
        chk_cnt("stats_count", 32'd5, 32'd1);
        force dut.hit_count_q = 32'hFFFF_FFFE;
        @(negedge clk);
        release dut.hit_count_q;
        for (int i = 0; i < 3; i++) cyc();
        chk_cnt("stats_sat", 32'hFFFF_FFFF, 32'd1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
